// File: rtl/framebuffer_pkg.sv
// Shared defaults, pixel type and arbiter state encoding
// for the framebuffer arbiter slice.
package framebuffer_pkg;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 18;
    localparam int STARVE_MAX = 8;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE
    } state_e;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// Scan, host and RAM signals of the framebuffer arbiter.
// slave = arbiter view, master = surrounding system view.
interface framebuffer_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 18
);

    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_gnt;
    logic [DATA_W-1:0] scan_rdata;
    logic              scan_rvalid;
    logic              frame_start;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              swap_req;
    logic              swap_done;

    logic [ADDR_W:0]   ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  scan_req, scan_addr, frame_start,
        input  wr_valid, wr_addr, wr_data, swap_req,
        input  ram_rdata,
        output scan_gnt, scan_rdata, scan_rvalid,
        output wr_ready, swap_done,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output scan_req, scan_addr, frame_start,
        output wr_valid, wr_addr, wr_data, swap_req,
        output ram_rdata,
        input  scan_gnt, scan_rdata, scan_rvalid,
        input  wr_ready, swap_done,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/fb_starve_counter.sv
// Saturating count of cycles a host write has been held off;
// starved flags that the write must be forced through.
module fb_starve_counter #(
    parameter int STARVE_MAX = framebuffer_pkg::STARVE_MAX
) (
    input  logic clk_in,
    input  logic reset,
    input  logic stall,
    output logic starved
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count;

    // Count stalled cycles, clear on any non-stall cycle, hold at MAX
    always_ff @(posedge clk_in) begin
        if (reset || !stall) begin
            count <= '0;
        end else if (count != MAX) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (count == MAX);

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: scan reads win unless a host
// write has starved. Define FB_DOUBLE_BUFFER_EN for bank swapping.
module framebuffer_arbiter #(
    parameter int ADDR_W     = framebuffer_pkg::ADDR_W,
    parameter int DATA_W     = framebuffer_pkg::DATA_W,
    parameter int STARVE_MAX = framebuffer_pkg::STARVE_MAX
) (
    input logic                  clk_in,
    input logic                  reset,
    framebuffer_arbiter_if.slave bus
);

    import framebuffer_pkg::*;

    state_e          state;
    logic            starved;
    logic            host_win;
    logic            scan_win;
    logic            front_bank;
    logic            back_bank;
    logic [ADDR_W:0] addr_q;
    logic [ADDR_W:0] addr_d;

    fb_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk_in (clk_in),
        .reset  (reset),
        .stall  (bus.wr_valid && !host_win),
        .starved(starved)
    );

    assign host_win = !reset && bus.wr_valid
                      && (!bus.scan_req || starved);
    assign scan_win = !reset && bus.scan_req && !host_win;

    // Pick the RAM address for the winner; hold it when idle
    always_comb begin
        addr_d = addr_q;
        if (reset) begin
            addr_d = '0;
        end else if (host_win) begin
            addr_d = {back_bank, bus.wr_addr};
        end else if (scan_win) begin
            addr_d = {front_bank, bus.scan_addr};
        end
    end

    // Remember the last driven address for idle cycles
    always_ff @(posedge clk_in) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Track last cycle's grant; SCAN marks read data due now
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else if (scan_win) begin
            state <= SCAN;
        end else if (host_win) begin
            state <= WRITE;
        end else begin
            state <= IDLE;
        end
    end

    assign bus.scan_gnt    = scan_win;
    assign bus.wr_ready    = host_win;
    assign bus.ram_we      = host_win;
    assign bus.ram_addr    = addr_d;
    assign bus.ram_wdata   = host_win ? bus.wr_data : '0;
    assign bus.scan_rvalid = (state == SCAN) && !reset;
    assign bus.scan_rdata  = bus.scan_rvalid ? bus.ram_rdata : '0;

`ifdef FB_DOUBLE_BUFFER_EN
    logic swap_pending;
    logic swap_done_q;

    // Hold swap requests until the next frame boundary
    always_ff @(posedge clk_in) begin
        if (reset) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            if (bus.frame_start && (swap_pending || bus.swap_req)) begin
                front_bank   <= ~front_bank;
                swap_pending <= 1'b0;
                swap_done_q  <= 1'b1;
            end else if (bus.swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign back_bank     = ~front_bank;
    assign bus.swap_done = swap_done_q && !reset;
`else
    logic unused_swap;

    assign unused_swap   = bus.swap_req ^ bus.frame_start;
    assign front_bank    = 1'b0;
    assign back_bank     = 1'b0;
    assign bus.swap_done = 1'b0;
`endif

endmodule

// File: doc/framebuffer_arbiter.md
FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter ADDR_W, 11, pixel address width (64x32 panel = 2048 pixels).
REQ-002 Parameter DATA_W, 18, pixel width (6-bit red, green, blue; red in LSBs).
REQ-003 Parameter STARVE_MAX, 8, maximum number of cycles a host write waits before it is forced through.
REQ-004 clk_in  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 scan_req  in  1  scan side requests a pixel read.
REQ-007 scan_addr  in  ADDR_W  scan read address.
REQ-008 scan_gnt  out  1  scan read accepted this cycle.
REQ-009 scan_rdata  out  DATA_W  read pixel data.
REQ-010 scan_rvalid  out  1  scan_rdata valid.
REQ-011 frame_start  in  1  one-cycle pulse from the scanner at the frame boundary.
REQ-012 wr_valid  in  1  host write request.
REQ-013 wr_ready  out  1  host write accepted this cycle.
REQ-014 wr_addr  in  ADDR_W  host write address.
REQ-015 wr_data  in  DATA_W  host write data.
REQ-016 swap_req  in  1  host requests a buffer swap.
REQ-017 swap_done  out  1  one-cycle pulse when the swap takes effect.
REQ-018 ram_addr  out  ADDR_W+1  single-port RAM address; MSB = bank.
REQ-019 ram_we  out  1  RAM write enable.
REQ-020 ram_wdata  out  DATA_W  RAM write data.
REQ-021 ram_rdata  in  DATA_W  RAM read data, 1-cycle registered latency.

Function
REQ-022 One RAM access per cycle; the grant decision is combinational from the current inputs and registered state.
REQ-023 Default priority: scan_req wins; wr_ready=0 while scan_req=1.
REQ-024 Starve counter: increments each cycle wr_valid=1 and wr_ready=0; clears on any cycle with wr_ready=1 or wr_valid=0; saturates at STARVE_MAX.
REQ-025 Counter == STARVE_MAX with wr_valid=1: the host is granted and scan_gnt=0 that cycle, even with scan_req=1.
REQ-026 Neither side requesting: ram_we=0, and ram_addr holds its last value.
REQ-027 Scan grant: scan_gnt=1, ram_we=0, ram_addr={front_bank, scan_addr}.
REQ-028 Host grant: wr_ready=1, ram_we=1, ram_addr={back_bank, wr_addr}, ram_wdata=wr_data.
REQ-029 Latency: scan_rvalid=1 exactly one cycle after scan_gnt=1, with scan_rdata=ram_rdata; scan_rvalid=0 otherwise.
REQ-030 FSM states: IDLE, SCAN, WRITE, where the state reflects the previous cycle's grant.
REQ-031 Transitions: to SCAN on a scan grant, to WRITE on a host grant, else to IDLE.
REQ-032 scan_rvalid is asserted in SCAN.
REQ-033 swap_req sets the swap_pending flag.
REQ-034 frame_start with swap_pending set: front_bank toggles, pending clears and swap_done pulses on the next cycle.
REQ-035 swap_req and frame_start in the same cycle: the swap takes effect on that frame_start.
REQ-036 A grant in the same cycle as a swap uses the pre-swap bank values.

Reset
REQ-037 While reset=1: scan_gnt, scan_rvalid, wr_ready, ram_we and swap_done are 0; ram_addr and scan_rdata are 0.
REQ-038 While reset=1: the FSM is IDLE, the starve counter is 0, front_bank is 0 and swap_pending is 0.
REQ-039 Reset during SCAN drops the pending scan_rvalid.
REQ-040 Reset asserted in the same cycle as wr_valid does not accept the write.

Configuration
REQ-041 Macro FB_DOUBLE_BUFFER_EN defined: two banks; back_bank = ~front_bank; swap logic as in REQ-033 to REQ-036.
REQ-042 FB_DOUBLE_BUFFER_EN undefined: ram_addr MSB is always 0, back_bank = front_bank = 0, swap_req is ignored and swap_done is tied to 0.

Structure
REQ-043 Package framebuffer_pkg holds ADDR_W, DATA_W and STARVE_MAX defaults, the pixel typedef (DATA_W bits) and the FSM state enum (IDLE, SCAN, WRITE).
REQ-044 Sub-module fb_starve_counter implements the saturating counter and outputs a starved flag; the arbitration and swap logic stay in the top module.

Verification
REQ-045 Alternating scan_req at addr 0x005 with RAM preloaded with 0x3F000 -> scan_gnt in the request cycle; scan_rvalid and scan_rdata=0x3F000 one cycle later.
REQ-046 Continuous scan_req with wr_valid held at addr 0x010, data 0x00ABC -> wr_ready=1 on exactly the 9th cycle (STARVE_MAX=8); scan_gnt=0 that cycle; RAM[0x010]=0x00ABC.
REQ-047 FB_DOUBLE_BUFFER_EN defined: write to addr 0x000 -> ram_addr=0x800; swap_req then frame_start -> swap_done the next cycle; a scan read of 0x000 afterwards -> ram_addr=0x800.
REQ-048 swap_req and frame_start in the same cycle -> swap_done one cycle later; a second frame_start with no new swap_req -> no toggle.
REQ-049 Reset asserted the cycle after scan_gnt -> scan_rvalid=0, all outputs 0, and the starve counter reads 0 after release.
REQ-050 FB_DOUBLE_BUFFER_EN undefined: swap_req and frame_start pulses -> swap_done stays 0 and the ram_addr MSB stays 0.
